// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths, responder FSM state encoding and wait-counter width.
package wb_pkg;

   localparam int unsigned WB_ADDR_W  = 16;
   localparam int unsigned WB_DATA_W  = 8;
   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wishbone_slave_mem_if.sv
// Classic-cycle Wishbone bus bundle between the CPU-side master and the memory responder.
interface wishbone_slave_mem_if;
   import wb_pkg::*;

   logic                 cyc_i;
   logic                 stb_i;
   logic                 we_i;
   logic [WB_ADDR_W-1:0] adr_i;
   logic [WB_DATA_W-1:0] dat_i;
   logic [WB_DATA_W-1:0] dat_o;
   logic                 ack_o;

   modport slave (
      input  cyc_i,
      input  stb_i,
      input  we_i,
      input  adr_i,
      input  dat_i,
      output dat_o,
      output ack_o
   );

   modport master (
      output cyc_i,
      output stb_i,
      output we_i,
      output adr_i,
      output dat_i,
      input  dat_o,
      input  ack_o
   );

endinterface

// File: rtl/wishbone_slave_ram.sv
// Single-port byte RAM: synchronous write, registered read whose output holds between reads.
module wishbone_slave_ram
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [WB_DATA_W-1:0] wdata_i,
   output logic [WB_DATA_W-1:0] rdata_o
);

   logic [WB_DATA_W-1:0] mem_q [2**ADDR_BITS];
   logic [WB_DATA_W-1:0] rdata_q;

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_slave_mem.sv
// Wishbone classic responder: window decode, programmable wait states, one-cycle registered ack.
module wishbone_slave_mem
   import wb_pkg::*;
#(
   parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 16'h8000,
   parameter int unsigned          ADDR_BITS   = 8,
   parameter int unsigned          WAIT_STATES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   wishbone_slave_mem_if.slave   bus
);

   localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   wb_state_e             state_q;
   logic [WAIT_CNT_W-1:0] cnt_q;
   logic                  ack_q;

   logic hit;
   logic req;
   logic access;
   logic wr_en;
   logic rd_en;

   assign hit = (bus.adr_i[WB_ADDR_W-1:ADDR_BITS] == BASE_ADDR[WB_ADDR_W-1:ADDR_BITS]);
   assign req = bus.cyc_i & bus.stb_i & hit;

   // The RAM access happens on the same edge that moves the FSM into ACK.
   always_comb begin
      access = 1'b0;
      case (state_q)
         ST_IDLE: access = req && (WAIT_STATES == 0);
         ST_WAIT: access = req && (cnt_q == '0);
         default: access = 1'b0;
      endcase
   end

   assign wr_en = access &  bus.we_i & ~rst_i;
   assign rd_en = access & ~bus.we_i & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WS_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            // Inputs are ignored here so a held strobe cannot repeat the access.
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   wishbone_slave_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_en),
      .re_i    (rd_en),
      .addr_i  (bus.adr_i[ADDR_BITS-1:0]),
      .wdata_i (bus.dat_i),
      .rdata_o (bus.dat_o)
   );

   assign bus.ack_o = ack_q;

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Bench for wishbone_slave_mem: one responder with no wait states, one with three.
module tb_wishbone_slave_mem;

   localparam int WS0 = 0;
   localparam int WS3 = 3;

   logic clk;
   logic rst;

   wishbone_slave_mem_if bus0();
   wishbone_slave_mem_if bus3();

   wishbone_slave_mem #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .WAIT_STATES(WS0)) u_dut0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus0)
   );

   wishbone_slave_mem #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .WAIT_STATES(WS3)) u_dut3 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dat;
      logic [7:0]  exp_dat;
   } vec_t;

   vec_t        tbl [8];
   logic [7:0]  exp_q [$];
   int          total = 0;
   int          bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_bus(input int sel, input logic c, input logic s, input logic w,
                          input logic [15:0] a, input logic [7:0] d);
      if (sel == 0) begin
         bus0.cyc_i = c; bus0.stb_i = s; bus0.we_i = w; bus0.adr_i = a; bus0.dat_i = d;
      end else begin
         bus3.cyc_i = c; bus3.stb_i = s; bus3.we_i = w; bus3.adr_i = a; bus3.dat_i = d;
      end
   endtask

   function automatic logic get_ack(input int sel);
      return (sel == 0) ? bus0.ack_o : bus3.ack_o;
   endfunction

   function automatic logic [7:0] get_dat(input int sel);
      return (sel == 0) ? bus0.dat_o : bus3.dat_o;
   endfunction

   function automatic int ws_of(input int sel);
      return (sel == 0) ? WS0 : WS3;
   endfunction

   // One full transfer; strobe stays up through the ack cycle, then drops in the following IDLE cycle.
   task automatic xfer(input string name, input int sel, input logic we,
                       input logic [15:0] adr, input logic [7:0] dat, input logic [7:0] exp_dat);
      int         lat;
      bit         seen;
      logic [7:0] exp;
      if (!we) exp_q.push_back(exp_dat);
      set_bus(sel, 1'b1, 1'b1, we, adr, dat);
      seen = 1'b0;
      lat  = 0;
      for (int n = 1; n <= 20 && !seen; n++) begin
         tick();
         if (get_ack(sel)) begin
            seen = 1'b1;
            lat  = n;
         end
      end
      chk({name, " ack_latency"}, 32'(lat), 32'(ws_of(sel) + 1));
      if (!we) begin
         exp = exp_q.pop_front();
         if (seen) chk({name, " dat_o"}, 32'(get_dat(sel)), 32'(exp));
      end
      tick();
      chk({name, " ack_single"}, 32'(get_ack(sel)), 32'd0);
      set_bus(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic miss(input string name, input int sel, input logic [15:0] adr);
      int acks;
      acks = 0;
      set_bus(sel, 1'b1, 1'b1, 1'b1, adr, 8'hFF);
      repeat (20) begin
         tick();
         if (get_ack(sel)) acks++;
      end
      chk({name, " no_ack"}, 32'(acks), 32'd0);
      set_bus(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      tick();
   endtask

   initial begin
      tbl[0] = '{sel: 0, we: 1'b1, adr: 16'h8010, dat: 8'hA5, exp_dat: 8'h00};
      tbl[1] = '{sel: 0, we: 1'b0, adr: 16'h8010, dat: 8'h00, exp_dat: 8'hA5};
      tbl[2] = '{sel: 1, we: 1'b1, adr: 16'h80FF, dat: 8'hC3, exp_dat: 8'h00};
      tbl[3] = '{sel: 1, we: 1'b0, adr: 16'h80FF, dat: 8'h00, exp_dat: 8'hC3};
      tbl[4] = '{sel: 1, we: 1'b1, adr: 16'h8020, dat: 8'h5A, exp_dat: 8'h00};
      tbl[5] = '{sel: 0, we: 1'b1, adr: 16'h80AB, dat: 8'h0F, exp_dat: 8'h00};
      tbl[6] = '{sel: 0, we: 1'b0, adr: 16'h80AB, dat: 8'h00, exp_dat: 8'h0F};
      tbl[7] = '{sel: 1, we: 1'b1, adr: 16'h8030, dat: 8'h44, exp_dat: 8'h00};

      set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      rst = 1'b1;
      tick();
      tick();
      chk("reset ack0", 32'(bus0.ack_o), 32'd0);
      chk("reset dat0", 32'(bus0.dat_o), 32'd0);
      chk("reset ack3", 32'(bus3.ack_o), 32'd0);
      chk("reset dat3", 32'(bus3.dat_o), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         xfer($sformatf("vec%0d", i), tbl[i].sel, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].exp_dat);
      end

      // Out-of-window writes must neither respond nor alias onto 0x8010.
      miss("miss_7F10", 0, 16'h7F10);
      miss("miss_9000", 0, 16'h9000);
      miss("miss3_9000", 1, 16'h9010);
      xfer("miss_readback", 0, 1'b0, 16'h8010, 8'h00, 8'hA5);

      // Strobe drops in cycle 2 of the wait phase: write is abandoned.
      begin
         int acks;
         acks = 0;
         set_bus(1, 1'b1, 1'b1, 1'b1, 16'h8020, 8'h3C);
         tick();
         tick();
         set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
         repeat (8) begin
            tick();
            if (bus3.ack_o) acks++;
         end
         chk("abort no_ack", 32'(acks), 32'd0);
      end
      xfer("abort_readback", 1, 1'b0, 16'h8020, 8'h00, 8'h5A);

      // Back-to-back writes with strobe never released.
      set_bus(0, 1'b1, 1'b1, 1'b1, 16'h8001, 8'h11);
      tick();
      chk("b2b ack1", 32'(bus0.ack_o), 32'd1);
      set_bus(0, 1'b1, 1'b1, 1'b1, 16'h8002, 8'h22);
      tick();
      chk("b2b idle_gap", 32'(bus0.ack_o), 32'd0);
      tick();
      chk("b2b ack2", 32'(bus0.ack_o), 32'd1);
      set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      tick();
      chk("b2b after", 32'(bus0.ack_o), 32'd0);
      tick();
      chk("b2b quiet", 32'(bus0.ack_o), 32'd0);
      xfer("b2b_rd1", 0, 1'b0, 16'h8001, 8'h00, 8'h11);
      xfer("b2b_rd2", 0, 1'b0, 16'h8002, 8'h00, 8'h22);

      // Reset lands while the 0x77 write is still waiting.
      set_bus(1, 1'b1, 1'b1, 1'b1, 16'h8030, 8'h77);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rst ack3", 32'(bus3.ack_o), 32'd0);
      chk("rst dat3", 32'(bus3.dat_o), 32'd0);
      chk("rst dat0", 32'(bus0.dat_o), 32'd0);
      rst = 1'b0;
      set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      begin
         int acks;
         acks = 0;
         repeat (6) begin
            tick();
            if (bus3.ack_o) acks++;
         end
         chk("rst no_ack", 32'(acks), 32'd0);
      end
      xfer("rst_rd8030", 1, 1'b0, 16'h8030, 8'h00, 8'h44);
      xfer("rst_rd8010", 0, 1'b0, 16'h8010, 8'h00, 8'hA5);
      xfer("rst_rd80FF", 1, 1'b0, 16'h80FF, 8'h00, 8'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
